spi_target: RTL and testbench

SPI target (responder) for the far end of the SPI controller link: a Motorola mode 0 (CPOL=0, CPHA=0), MSB-first, 8-bit-frame slave that samples the external SCLK/SS/SDI pins into the PCLK domain. It sits behind a simple valid/ready byte interface: one-entry TX holding register in, per-frame RX byte pulse out. It lets a second FPGA or subsystem answer the on-chip SPI controller without any clock-domain crossing beyond the input synchronizers.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_in_sync.sv | 39 +++
 rtl/spi_target.sv | 202 ++++++++++++++++++++
 tb/tb_spi_target.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the controller-side and target-side logic.
package spi_pkg;

  localparam int unsigned SPI_FRAME_SIZE = 8;
  localparam logic [7:0]  SPI_TX_IDLE    = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // Width of a counter holding 0..n-1 (at least one bit).
  function automatic int unsigned spi_cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : spi_pkg

// File: rtl/spi_in_sync.sv
// Multi-stage input synchronizer with registered rise/fall strobes.
// level_o is the history flop, so it is aligned with the strobes.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_q;
  logic                   fall_q;

  // Synchronizer chain, history flop and edge strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
    end
  end

  assign level_o = hist_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule : spi_in_sync

// File: rtl/spi_target.sv
// SPI mode-0 target: MSB-first frames sampled into the PCLK domain,
// one-entry TX holding register, per-frame RX byte pulse.
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned           FRAME_SIZE  = SPI_FRAME_SIZE,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [FRAME_SIZE-1:0] TX_IDLE     = FRAME_SIZE'(SPI_TX_IDLE)
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  SPISCLK,
  input  logic                  SPISS,
  input  logic                  SPISDI,
  output logic                  SPISDO,
  output logic                  SPIOEN,
  input  logic [FRAME_SIZE-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [FRAME_SIZE-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_abort
);

  localparam int unsigned CNT_W = spi_cnt_width(FRAME_SIZE);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic ss_level_unused, ss_rise, ss_fall;
  logic sdi_sync, sdi_rise_unused, sdi_fall_unused;

  spi_state_e            state_q, state_d;
  logic [FRAME_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_SIZE-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  reload_q, reload_d;
  logic [FRAME_SIZE-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [FRAME_SIZE-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  abort_q, abort_d;
  logic                  sdo_q, sdo_d;
  logic                  oen_q, oen_d;
  logic                  load_c;
  logic                  wr_en_c;
  logic [FRAME_SIZE-1:0] rx_next_c;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .pin_i   (SPISCLK),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .pin_i   (SPISS),
    .level_o (ss_level_unused),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .pin_i   (SPISDI),
    .level_o (sdi_sync),
    .rise_o  (sdi_rise_unused),
    .fall_o  (sdi_fall_unused)
  );

  // State and datapath registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= IDLE;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      bit_cnt_q    <= '0;
      reload_q     <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_ready_q   <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      underrun_q   <= 1'b0;
      abort_q      <= 1'b0;
      sdo_q        <= 1'b0;
      oen_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      bit_cnt_q    <= bit_cnt_d;
      reload_q     <= reload_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_ready_q   <= tx_ready_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      underrun_q   <= underrun_d;
      abort_q      <= abort_d;
      sdo_q        <= sdo_d;
      oen_q        <= oen_d;
    end
  end

  // Frame FSM, shifters, TX reload and holding-register write.
  always_comb begin
    state_d      = state_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    bit_cnt_d    = bit_cnt_q;
    reload_d     = reload_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    underrun_d   = 1'b0;
    abort_d      = 1'b0;
    load_c       = 1'b0;
    wr_en_c      = tx_valid && tx_ready_q;
    rx_next_c    = {rx_shift_q[FRAME_SIZE-2:0], sdi_sync};

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          reload_d   = 1'b0;
          rx_shift_d = '0;
          load_c     = 1'b1;
        end
      end
      ACTIVE: begin
        // SS release takes priority over a coincident SCLK edge.
        if (ss_rise) begin
          state_d    = IDLE;
          abort_d    = (bit_cnt_q != '0);
          bit_cnt_d  = '0;
          reload_d   = 1'b0;
          rx_shift_d = '0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = rx_next_c;
            if (bit_cnt_q == CNT_W'(FRAME_SIZE - 1)) begin
              rx_data_d  = rx_next_c;
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
              reload_d   = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          if (sclk_fall) begin
            if (reload_q) begin
              load_c   = 1'b1;
              reload_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[FRAME_SIZE-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load drains the holding register, or sends the idle byte if empty.
    if (load_c) begin
      if (hold_valid_q) begin
        tx_shift_d   = hold_q;
        hold_valid_d = 1'b0;
      end else begin
        tx_shift_d = TX_IDLE;
        underrun_d = 1'b1;
      end
    end

    // Writes only happen into an empty register, so they never collide with a drain.
    if (wr_en_c) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end

    tx_ready_d = !hold_valid_d;
    oen_d      = (state_d == ACTIVE);
    sdo_d      = (state_d == ACTIVE) ? tx_shift_d[FRAME_SIZE-1] : 1'b0;
  end

  assign SPISDO      = sdo_q;
  assign SPIOEN      = oen_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_abort = abort_q;

endmodule : spi_target

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: mode-0 controller model driving the pins.
module tb_spi_target;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       SPISCLK;
  logic       SPISS;
  logic       SPISDI;
  logic       SPISDO;
  logic       SPIOEN;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       frame_abort;

  int total = 0;
  int bad   = 0;

  int rx_pulses = 0;
  int ur_pulses = 0;
  int ab_pulses = 0;

  spi_target dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .SPISCLK     (SPISCLK),
    .SPISS       (SPISS),
    .SPISDI      (SPISDI),
    .SPISDO      (SPISDO),
    .SPIOEN      (SPIOEN),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .frame_abort (frame_abort)
  );

  always #5 PCLK = ~PCLK;

  // Count pulse-output cycles, sampled away from the active edge.
  always @(negedge PCLK) begin
    if (rx_valid === 1'b1)    rx_pulses++;
    if (tx_underrun === 1'b1) ur_pulses++;
    if (frame_abort === 1'b1) ab_pulses++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_tx(input logic [7:0] d);
    @(negedge PCLK);
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL write_ready: tx_ready=%b expected 1", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge PCLK);
    #1;
    tx_valid = 1'b0;
  endtask

  // SCLK half period is 8 PCLK; all pin changes land on PCLK falling edges.
  task automatic spi_xfer(input logic [7:0] mosi, input int nbits, input bit start,
                          input bit hold_ss, output logic [7:0] miso, output bit oen_ok);
    miso   = 8'h00;
    oen_ok = 1'b1;
    @(negedge PCLK);
    if (start) SPISS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      SPISDI = mosi[7-i];
      #80;
      miso[7-i] = SPISDO;
      if (SPIOEN !== 1'b1) oen_ok = 1'b0;
      SPISCLK = 1'b1;
      #80;
      SPISCLK = 1'b0;
      if (i == nbits - 1 && !hold_ss) SPISS = 1'b1;
    end
    #80;
  endtask

  task automatic test_reset();
    PRESET   = 1'b1;
    SPISCLK  = 1'b0;
    SPISS    = 1'b1;
    SPISDI   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (4) @(negedge PCLK);
    PRESET = 1'b0;
    repeat (3) @(negedge PCLK);
    total += 7;
    if (SPISDO !== 1'b0)      begin bad++; $display("FAIL rst_sdo: got %b expected 0", SPISDO); end
    if (SPIOEN !== 1'b0)      begin bad++; $display("FAIL rst_oen: got %b expected 0", SPIOEN); end
    if (tx_ready !== 1'b1)    begin bad++; $display("FAIL rst_tx_ready: got %b expected 1", tx_ready); end
    if (rx_valid !== 1'b0)    begin bad++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); end
    if (rx_data !== 8'h00)    begin bad++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
    if (tx_underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun: got %b expected 0", tx_underrun); end
    if (frame_abort !== 1'b0) begin bad++; $display("FAIL rst_abort: got %b expected 0", frame_abort); end
  endtask

  task automatic test_basic();
    logic [7:0] miso;
    bit         oen_ok;
    int         rx0, ur0;
    write_tx(8'hA5);
    @(negedge PCLK);
    total++;
    if (tx_ready !== 1'b0) begin bad++; $display("FAIL basic_full: tx_ready=%b expected 0", tx_ready); end
    rx0 = rx_pulses;
    ur0 = ur_pulses;
    spi_xfer(8'h3C, 8, 1'b1, 1'b0, miso, oen_ok);
    total += 6;
    if (miso !== 8'hA5)         begin bad++; $display("FAIL basic_miso: got %h expected a5", miso); end
    if (oen_ok !== 1'b1)        begin bad++; $display("FAIL basic_oen: SPIOEN low during frame"); end
    if (rx_data !== 8'h3C)      begin bad++; $display("FAIL basic_rx_data: got %h expected 3c", rx_data); end
    if (rx_pulses - rx0 != 1)   begin bad++; $display("FAIL basic_rx_valid: pulses %0d expected 1", rx_pulses - rx0); end
    if (ur_pulses - ur0 != 0)   begin bad++; $display("FAIL basic_underrun: pulses %0d expected 0", ur_pulses - ur0); end
    if (tx_ready !== 1'b1)      begin bad++; $display("FAIL basic_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_underrun();
    logic [7:0] miso;
    bit         oen_ok;
    int         rx0, ur0;
    rx0 = rx_pulses;
    ur0 = ur_pulses;
    spi_xfer(8'h5A, 8, 1'b1, 1'b0, miso, oen_ok);
    total += 4;
    if (miso !== 8'hFF)       begin bad++; $display("FAIL ur_miso: got %h expected ff", miso); end
    if (ur_pulses - ur0 != 1) begin bad++; $display("FAIL ur_count: pulses %0d expected 1", ur_pulses - ur0); end
    if (rx_pulses - rx0 != 1) begin bad++; $display("FAIL ur_rx_valid: pulses %0d expected 1", rx_pulses - rx0); end
    if (rx_data !== 8'h5A)    begin bad++; $display("FAIL ur_rx_data: got %h expected 5a", rx_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] miso1, miso2;
    bit         oen_ok;
    int         rx0, ur0;
    write_tx(8'h96);
    rx0 = rx_pulses;
    ur0 = ur_pulses;
    fork
      spi_xfer(8'hC3, 8, 1'b1, 1'b1, miso1, oen_ok);
      begin
        repeat (30) @(negedge PCLK);
        write_tx(8'h11);
      end
    join
    total += 2;
    if (miso1 !== 8'h96)   begin bad++; $display("FAIL b2b_miso1: got %h expected 96", miso1); end
    if (rx_data !== 8'hC3) begin bad++; $display("FAIL b2b_rx1: got %h expected c3", rx_data); end
    spi_xfer(8'h24, 8, 1'b0, 1'b0, miso2, oen_ok);
    total += 4;
    if (miso2 !== 8'h11)      begin bad++; $display("FAIL b2b_miso2: got %h expected 11", miso2); end
    if (rx_data !== 8'h24)    begin bad++; $display("FAIL b2b_rx2: got %h expected 24", rx_data); end
    if (rx_pulses - rx0 != 2) begin bad++; $display("FAIL b2b_rx_valid: pulses %0d expected 2", rx_pulses - rx0); end
    if (ur_pulses - ur0 != 0) begin bad++; $display("FAIL b2b_underrun: pulses %0d expected 0", ur_pulses - ur0); end
  endtask

  task automatic test_abort();
    logic [7:0] miso;
    bit         oen_ok;
    int         rx0, ab0;
    rx0 = rx_pulses;
    ab0 = ab_pulses;
    spi_xfer(8'hFF, 5, 1'b1, 1'b0, miso, oen_ok);
    total += 3;
    if (ab_pulses - ab0 != 1) begin bad++; $display("FAIL abort_pulse: pulses %0d expected 1", ab_pulses - ab0); end
    if (rx_pulses - rx0 != 0) begin bad++; $display("FAIL abort_rx_valid: pulses %0d expected 0", rx_pulses - rx0); end
    if (rx_data !== 8'h24)    begin bad++; $display("FAIL abort_rx_data: got %h expected 24", rx_data); end
    ab0 = ab_pulses;
    spi_xfer(8'h81, 8, 1'b1, 1'b0, miso, oen_ok);
    total += 3;
    if (rx_data !== 8'h81)    begin bad++; $display("FAIL abort_next_rx: got %h expected 81", rx_data); end
    if (rx_pulses - rx0 != 1) begin bad++; $display("FAIL abort_next_valid: pulses %0d expected 1", rx_pulses - rx0); end
    if (ab_pulses - ab0 != 0) begin bad++; $display("FAIL abort_next_abort: pulses %0d expected 0", ab_pulses - ab0); end
  endtask

  task automatic test_hold_full();
    logic [7:0] miso1, miso2;
    bit         oen_ok;
    int         ur0, early_ready, accepts;
    bit         oen_at_accept;
    write_tx(8'h77);
    ur0 = ur_pulses;
    @(negedge PCLK);
    tx_data     = 8'hEE;
    tx_valid    = 1'b1;
    early_ready = 0;
    repeat (10) begin
      @(negedge PCLK);
      if (tx_ready !== 1'b0) early_ready++;
    end
    accepts       = 0;
    oen_at_accept = 1'b0;
    fork
      spi_xfer(8'h42, 8, 1'b1, 1'b0, miso1, oen_ok);
      begin
        for (int c = 0; c < 100; c++) begin
          @(negedge PCLK);
          if (tx_ready === 1'b1) begin
            accepts++;
            oen_at_accept = SPIOEN;
            @(posedge PCLK);
            #1;
            tx_valid = 1'b0;
            break;
          end
        end
        tx_valid = 1'b0;
      end
    join
    total += 4;
    if (early_ready != 0)      begin bad++; $display("FAIL hold_blocked: ready cycles %0d expected 0", early_ready); end
    if (accepts != 1)          begin bad++; $display("FAIL hold_accept: accepts %0d expected 1", accepts); end
    if (oen_at_accept !== 1'b1) begin bad++; $display("FAIL hold_after_load: SPIOEN=%b expected 1", oen_at_accept); end
    if (miso1 !== 8'h77)       begin bad++; $display("FAIL hold_miso1: got %h expected 77", miso1); end
    spi_xfer(8'h18, 8, 1'b1, 1'b0, miso2, oen_ok);
    total += 2;
    if (miso2 !== 8'hEE)      begin bad++; $display("FAIL hold_miso2: got %h expected ee", miso2); end
    if (ur_pulses - ur0 != 0) begin bad++; $display("FAIL hold_underrun: pulses %0d expected 0", ur_pulses - ur0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] miso;
    bit         oen_ok;
    int         rx0, ab0;
    write_tx(8'h3A);
    rx0 = rx_pulses;
    ab0 = ab_pulses;
    spi_xfer(8'hF0, 3, 1'b1, 1'b1, miso, oen_ok);
    @(negedge PCLK);
    PRESET = 1'b1;
    SPISS  = 1'b1;
    repeat (4) @(negedge PCLK);
    total += 5;
    if (SPIOEN !== 1'b0)   begin bad++; $display("FAIL mid_oen: got %b expected 0", SPIOEN); end
    if (SPISDO !== 1'b0)   begin bad++; $display("FAIL mid_sdo: got %b expected 0", SPISDO); end
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b expected 1", tx_ready); end
    if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_rx_data: got %h expected 00", rx_data); end
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_rx_valid: got %b expected 0", rx_valid); end
    PRESET = 1'b0;
    repeat (6) @(negedge PCLK);
    total += 3;
    if (SPIOEN !== 1'b0)      begin bad++; $display("FAIL mid_idle: SPIOEN=%b expected 0", SPIOEN); end
    if (ab_pulses - ab0 != 0) begin bad++; $display("FAIL mid_abort: pulses %0d expected 0", ab_pulses - ab0); end
    if (rx_pulses - rx0 != 0) begin bad++; $display("FAIL mid_rx_pulse: pulses %0d expected 0", rx_pulses - rx0); end
    spi_xfer(8'hB4, 8, 1'b1, 1'b0, miso, oen_ok);
    total += 3;
    if (rx_data !== 8'hB4)    begin bad++; $display("FAIL mid_next_rx: got %h expected b4", rx_data); end
    if (miso !== 8'hFF)       begin bad++; $display("FAIL mid_next_miso: got %h expected ff", miso); end
    if (rx_pulses - rx0 != 1) begin bad++; $display("FAIL mid_next_valid: pulses %0d expected 1", rx_pulses - rx0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_hold_full();
    test_reset_mid();
    repeat (4) @(negedge PCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_spi_target
